// File: rtl/word_disp_pkg.sv
// Shared types and helpers for the three-digit "dE1" word display.
package word_disp_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] POS0 = 2'b00;
  localparam logic [SEL_W-1:0] POS1 = 2'b01;
  localparam logic [SEL_W-1:0] POS2 = 2'b10;

  typedef enum logic [SEL_W-1:0] {
    P0 = 2'b00,
    P1 = 2'b01,
    P2 = 2'b10
  } pos_e;

  // Map the unused code 11 back to the home position.
  function automatic logic [SEL_W-1:0] coerce_pos(input logic [SEL_W-1:0] pos);
    coerce_pos = (pos == 2'b11) ? POS0 : pos;
  endfunction

  function automatic logic [SEL_W-1:0] next_pos(input logic [SEL_W-1:0] pos,
                                                input logic             dir);
    case (pos)
      POS0:    next_pos = dir ? POS2 : POS1;
      POS1:    next_pos = dir ? POS0 : POS2;
      POS2:    next_pos = dir ? POS1 : POS0;
      default: next_pos = POS0;
    endcase
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer plus falling-edge detector for an active-low key.
module key_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_n_i,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Preset to the released level so reset release never looks like a press.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= key_n_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/word_rotate_ctrl.sv
// Rotation sequencer for the word display: prescaled auto-advance, key step, preset.
module word_rotate_ctrl
  import word_disp_pkg::*;
#(
  parameter int TICK_COUNT = 50_000_000,
  parameter int CW         = 26
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic             Dir,
  input  logic             Step_n,
  input  logic             Load,
  input  logic [SEL_W-1:0] LoadSel,
  output logic [SEL_W-1:0] Sel,
  output logic [2:0]       Pos,
  output logic             Adv
);

  logic [CW-1:0] cnt_q, cnt_d;
  pos_e          state_q, state_d;
  logic          adv_q, adv_d;
  logic          tick, step, advance;

  key_sync_edge u_step (
    .clk_i   (Clock),
    .rst_n_i (Resetn),
    .key_n_i (Step_n),
    .fall_o  (step)
  );

  assign tick    = Run && (cnt_q == CW'(TICK_COUNT - 1));
  assign advance = tick | step;

  always_comb begin
    cnt_d = cnt_q;
    if (Load)      cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (Run)  cnt_d = cnt_q + CW'(1);
  end

  // Load outranks any advance; a simultaneous tick and step merge into one.
  always_comb begin
    state_d = state_q;
    adv_d   = 1'b0;
    if (Load) begin
      state_d = pos_e'(coerce_pos(LoadSel));
    end else if (advance) begin
      state_d = pos_e'(next_pos(state_q, Dir));
      adv_d   = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q   <= '0;
      state_q <= P0;
      adv_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      adv_q   <= adv_d;
    end
  end

  assign Sel = state_q;
  assign Adv = adv_q;

  always_comb begin
    case (state_q)
      P1:      Pos = 3'b010;
      P2:      Pos = 3'b100;
      default: Pos = 3'b001;
    endcase
  end

endmodule

// File: tb/tb_word_rotate_ctrl.sv
// Randomized and directed bench for word_rotate_ctrl against a cycle-level reference model.
module tb_word_rotate_ctrl;

  localparam int TC = 4;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Run = 1'b0, Dir = 1'b0, Step_n = 1'b1, Load = 1'b0;
  logic [1:0] LoadSel = 2'b00;
  logic [1:0] Sel;
  logic [2:0] Pos;
  logic       Adv;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: position 0..2, prescaler, Adv, last three Step_n samples.
  int msel = 0, mcnt = 0;
  bit madv = 0;
  bit h1 = 1, h2 = 1, h3 = 1;

  word_rotate_ctrl #(.TICK_COUNT(TC), .CW(3)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Run     (Run),
    .Dir     (Dir),
    .Step_n  (Step_n),
    .Load    (Load),
    .LoadSel (LoadSel),
    .Sel     (Sel),
    .Pos     (Pos),
    .Adv     (Adv)
  );

  always #5 Clock = ~Clock;

  function automatic logic [5:0] exp_word();
    return {2'(msel), 3'(1 << msel), madv};
  endfunction

  task automatic model_reset();
    msel = 0; mcnt = 0; madv = 0;
    h1 = 1; h2 = 1; h3 = 1;
  endtask

  // One rising edge for DUT and model, then settle to the falling edge.
  task automatic clk_edge();
    bit tk, st, ad;
    @(posedge Clock);
    tk = Run && (mcnt == TC - 1);
    st = !h2 && h3;
    ad = tk || st;
    if (Load) begin
      msel = (LoadSel == 2'b11) ? 0 : int'(LoadSel);
      mcnt = 0;
      madv = 0;
    end else begin
      if (ad) msel = Dir ? (msel + 2) % 3 : (msel + 1) % 3;
      madv = ad;
      if (Run) mcnt = (mcnt + 1) % TC;
    end
    h3 = h2; h2 = h1; h1 = Step_n;
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Resetn = 1'b0; Run = 0; Dir = 0; Step_n = 1; Load = 0; LoadSel = 0;
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({Sel, Pos, Adv} !== 6'b00_001_0) begin
      miscompares++;
      $display("FAIL reset: got %b want %b", {Sel, Pos, Adv}, 6'b00_001_0);
    end
    do_reset();
  endtask

  task automatic test_forward();
    int mask = 0;
    do_reset();
    Run = 1; Dir = 0;
    for (int c = 1; c <= 13; c++) begin
      clk_edge();
      if (Adv) mask |= (1 << c);
      vectors++;
      if ({Sel, Pos, Adv} !== exp_word()) begin
        miscompares++;
        $display("FAIL fwd edge%0d: got %b want %b", c, {Sel, Pos, Adv}, exp_word());
      end
    end
    vectors++;
    if (mask !== ((1 << 4) | (1 << 8) | (1 << 12))) begin
      miscompares++;
      $display("FAIL fwd adv_edges: got %h want %h", mask, (1 << 4) | (1 << 8) | (1 << 12));
    end
  endtask

  task automatic test_reverse();
    logic [1:0] want [4] = '{2'b10, 2'b01, 2'b00, 2'b01};
    do_reset();
    Run = 1; Dir = 1;
    for (int c = 1; c <= 17; c++) begin
      clk_edge();
      if (c == 14) Dir = 0;
      vectors++;
      if ({Sel, Pos, Adv} !== exp_word()) begin
        miscompares++;
        $display("FAIL rev edge%0d: got %b want %b", c, {Sel, Pos, Adv}, exp_word());
      end
      if (c % 4 == 0) begin
        vectors++;
        if (Sel !== want[c / 4 - 1]) begin
          miscompares++;
          $display("FAIL rev seq edge%0d: got %b want %b", c, Sel, want[c / 4 - 1]);
        end
      end
    end
  endtask

  task automatic test_step();
    bit pat [13] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    int mask = 0;
    do_reset();
    Run = 0; Dir = 0;
    for (int i = 0; i < 13; i++) begin
      Step_n = pat[i];
      clk_edge();
      if (Adv) mask |= (1 << (i + 1));
      vectors++;
      if ({Sel, Pos, Adv} !== exp_word()) begin
        miscompares++;
        $display("FAIL step edge%0d: got %b want %b", i + 1, {Sel, Pos, Adv}, exp_word());
      end
    end
    vectors++;
    if (mask !== ((1 << 3) | (1 << 9)) || Sel !== 2'b10) begin
      miscompares++;
      $display("FAIL step summary: got adv=%h sel=%b want adv=%h sel=10", mask, Sel, (1 << 3) | (1 << 9));
    end
    // The prescaler must still be at 0: the first tick needs a full interval.
    Run = 1;
    for (int c = 1; c <= 4; c++) begin
      clk_edge();
      vectors++;
      if (Sel !== ((c == 4) ? 2'b00 : 2'b10)) begin
        miscompares++;
        $display("FAIL step cnt edge%0d: got %b want %b", c, Sel, (c == 4) ? 2'b00 : 2'b10);
      end
    end
  endtask

  task automatic test_coincide();
    int advs = 0;
    do_reset();
    Run = 1; Dir = 0;
    for (int c = 1; c <= 7; c++) begin
      Step_n = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      clk_edge();
      if (Adv) advs++;
      vectors++;
      if ({Sel, Pos, Adv} !== exp_word()) begin
        miscompares++;
        $display("FAIL coinc edge%0d: got %b want %b", c, {Sel, Pos, Adv}, exp_word());
      end
    end
    vectors++;
    if (advs != 1 || Sel !== 2'b01) begin
      miscompares++;
      $display("FAIL coinc summary: got advs=%0d sel=%b want advs=1 sel=01", advs, Sel);
    end
  endtask

  task automatic test_load();
    logic [1:0] ls   [6] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [1:0] want [6] = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    do_reset();
    Run = 1; Dir = 0;
    repeat (3) clk_edge();
    for (int i = 0; i < 6; i++) begin
      Load = (i < 5);
      LoadSel = ls[i];
      clk_edge();
      vectors++;
      if ({Sel, Adv} !== {want[i], 1'b0} || {Sel, Pos, Adv} !== exp_word()) begin
        miscompares++;
        $display("FAIL load step%0d: got sel=%b adv=%b want sel=%b adv=0", i, Sel, Adv, want[i]);
      end
    end
    Load = 0;
    for (int c = 1; c <= 4; c++) begin
      clk_edge();
      vectors++;
      if ({Sel, Pos, Adv} !== exp_word()) begin
        miscompares++;
        $display("FAIL load after edge%0d: got %b want %b", c, {Sel, Pos, Adv}, exp_word());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    Run = 1; Dir = 0;
    repeat (8) clk_edge();
    #2;
    Resetn = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({Sel, Pos, Adv} !== 6'b00_001_0) begin
      miscompares++;
      $display("FAIL async_rst: got %b want %b", {Sel, Pos, Adv}, 6'b00_001_0);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      clk_edge();
      vectors++;
      if ({Sel, Pos, Adv} !== exp_word() || Sel !== ((c >= 4) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL async_rel edge%0d: got %b want %b", c, {Sel, Pos, Adv}, exp_word());
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      Run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) Dir = ~Dir;
      if (hold == 0) begin
        Step_n = $urandom_range(0, 1);
        hold = $urandom_range(1, 4);
      end
      hold--;
      Load = ($urandom_range(0, 15) == 0);
      LoadSel = 2'($urandom_range(0, 3));
      clk_edge();
      vectors++;
      if ({Sel, Pos, Adv} !== exp_word()) begin
        miscompares++;
        $display("FAIL rand cyc%0d: got %b want %b", c, {Sel, Pos, Adv}, exp_word());
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_step();
    test_coincide();
    test_load();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
